// File: rtl/launcher_pkg.sv
// Shared types and constants for the program launcher.
//   launcher_state_t : sequencer states (3-bit encoding)
//   NUM_PROGS        : number of resident programs launched in rotation
//   next_prog_idx    : rotation helper, 0 -> 1 -> 2 -> 0
package launcher_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    LAUNCH = 3'd2,
    RUN    = 3'd3,
    DONE   = 3'd4
  } launcher_state_t;

  localparam int unsigned NUM_PROGS = 3;
  localparam int unsigned IDX_W     = 2;

  // Wraps after the last program; the unused code 3 also returns to 0.
  function automatic logic [IDX_W-1:0] next_prog_idx(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] nxt;
    if (idx >= IDX_W'(NUM_PROGS - 1)) begin
      nxt = '0;
    end else begin
      nxt = idx + IDX_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : clear to zero (wins over inc)
//   inc      : increment by one, holding at all-ones
//   count    : registered count
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/program_launcher.sv
// Start/Ack sequencer that launches the resident programs P1..P3 in turn:
// loads the PC with the program base, enables the core until it halts,
// then acknowledges and keeps the run's cycle count for diagnostics.
//   Clk, Reset : clock, asynchronous active-high reset
//   Start      : request level from the bench (rise then fall = next program)
//   HaltReq    : core decoded a halt this cycle
//   PcLoad     : one-cycle PC load strobe
//   PcTarget   : base address for ProgIdx (combinational)
//   CoreEn     : core may fetch/execute
//   Ack        : program finished, held until the next Start
//   ProgIdx    : current / most recent program index
//   CycleCount : RUN cycles of the current / last program (saturating)
//   Fault      : sticky protocol error (Start seen while running)
module program_launcher
  import launcher_pkg::*;
#(
  parameter int unsigned PC_W    = 10,
  parameter int unsigned CYC_W   = 16,
  parameter int unsigned P1_BASE = 0,
  parameter int unsigned P2_BASE = 256,
  parameter int unsigned P3_BASE = 512
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             HaltReq,
  output logic             PcLoad,
  output logic [PC_W-1:0]  PcTarget,
  output logic             CoreEn,
  output logic             Ack,
  output logic [1:0]       ProgIdx,
  output logic [CYC_W-1:0] CycleCount,
  output logic             Fault
);

  launcher_state_t state_q;
  launcher_state_t state_d;
  logic            idx_adv;
  logic            fault_set;

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    idx_adv   = 1'b0;
    fault_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) state_d = ARMED;
      end
      ARMED: begin
        if (!Start) state_d = LAUNCH;
      end
      LAUNCH: begin
        state_d = RUN;
      end
      RUN: begin
        // A Start while running is a protocol error; the run carries on.
        if (Start) fault_set = 1'b1;
        if (HaltReq) state_d = DONE;
      end
      DONE: begin
        if (Start) begin
          state_d = ARMED;
          idx_adv = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobes are flopped from the next state so they track the state register
  // exactly and never glitch.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      PcLoad <= 1'b0;
      CoreEn <= 1'b0;
      Ack    <= 1'b0;
    end else begin
      PcLoad <= (state_d == LAUNCH);
      CoreEn <= (state_d == RUN);
      Ack    <= (state_d == DONE);
    end
  end

  // Program index and sticky fault
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ProgIdx <= 2'd0;
      Fault   <= 1'b0;
    end else begin
      if (idx_adv) ProgIdx <= next_prog_idx(ProgIdx);
      if (fault_set) Fault <= 1'b1;
    end
  end

  // Cleared on the edge into LAUNCH, so it reads 0 while PcLoad is high;
  // counts each RUN cycle including the one that samples the halt.
  sat_counter #(
    .W(CYC_W)
  ) u_cycle_cnt (
    .clk  (Clk),
    .rst  (Reset),
    .clr  ((state_d == LAUNCH) && (state_q != LAUNCH)),
    .inc  (state_q == RUN),
    .count(CycleCount)
  );

  // PC base mux
  always_comb begin
    PcTarget = PC_W'(P1_BASE);
    case (ProgIdx)
      2'd1:    PcTarget = PC_W'(P2_BASE);
      2'd2:    PcTarget = PC_W'(P3_BASE);
      default: PcTarget = PC_W'(P1_BASE);
    endcase
  end

endmodule
